// File: rtl/cosine_sim_sched_if.sv
// Requester/response bus between the client blocks and cosine_sim_sched.
// Vectors are packed per requester: requester r at [r*W*DW +: W*DW],
// element e inside it at [e*DW +: DW].
interface cosine_sim_sched_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 5,
    parameter int unsigned DW   = 32
);
    localparam int unsigned IDW = $clog2(NREQ);

    logic [NREQ-1:0]      req;
    logic [NREQ*W*DW-1:0] req_vec_a;
    logic [NREQ*W*DW-1:0] req_vec_b;
    logic [NREQ-1:0]      gnt;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [DW-1:0]        rsp_sim;
    logic                 rsp_err;

    // client side
    modport master (
        output req, req_vec_a, req_vec_b, rsp_ready,
        input  gnt, rsp_valid, rsp_id, rsp_sim, rsp_err
    );

    // scheduler side
    modport slave (
        input  req, req_vec_a, req_vec_b, rsp_ready,
        output gnt, rsp_valid, rsp_id, rsp_sim, rsp_err
    );
endinterface

// File: rtl/cosine_sim_sched.sv
// Round-robin scheduler sharing one cosine_sim engine between NREQ requesters.
// Grants one requester in IDLE, launches the engine with a one-cycle start,
// waits for the result under a watchdog and returns it tagged with the id.
module cosine_sim_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned W       = 5,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cosine_sim_sched_if.slave    bus,
    output logic                 eng_start,
    output logic [W*DW-1:0]      eng_vec_a,
    output logic [W*DW-1:0]      eng_vec_b,
    input  logic [DW-1:0]        eng_sim,
    input  logic                 eng_valid,
    output logic                 busy
);
    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned CW  = $clog2(TIMEOUT);
    localparam int unsigned VW  = W * DW;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP
    } state_t;

    state_t          state_q;
    logic [IDW-1:0]  rr_ptr_q;
    logic [CW-1:0]   cnt_q;
    logic            eng_start_q;
    logic            busy_q;
    logic            rsp_valid_q;
    logic            rsp_err_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [DW-1:0]   rsp_sim_q;
    logic [VW-1:0]   eng_vec_a_q;
    logic [VW-1:0]   eng_vec_b_q;

    logic [IDW-1:0]  win_d;
    logic            win_vld_d;
    logic [IDW-1:0]  rr_ptr_d;

    // Winner: first set request searching upward from rr_ptr, wrapping to 0.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        win_d     = '0;
        win_vld_d = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(rr_ptr_q) + k) % NREQ;
            if (!win_vld_d && bus.req[IDW'(idx)]) begin
                win_vld_d = 1'b1;
                win_d     = IDW'(idx);
            end
        end
        rr_ptr_d = (win_d == IDW'(NREQ - 1)) ? '0 : win_d + 1'b1;
    end

    // Grant is a combinational acceptance pulse, only offered while idle.
    always_comb begin
        bus.gnt = '0;
        if (state_q == IDLE && win_vld_d) begin
            bus.gnt = NREQ'(1) << win_d;
        end
    end

    // Scheduler FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            eng_start_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sim_q   <= '0;
            eng_vec_a_q <= '0;
            eng_vec_b_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (win_vld_d) begin
                        eng_vec_a_q <= bus.req_vec_a[32'(win_d) * VW +: VW];
                        eng_vec_b_q <= bus.req_vec_b[32'(win_d) * VW +: VW];
                        rsp_id_q    <= win_d;
                        rr_ptr_q    <= rr_ptr_d;
                        eng_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    eng_start_q <= 1'b0;
                    cnt_q       <= '0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    // A result in the final watchdog cycle still counts as a result.
                    if (eng_valid) begin
                        rsp_sim_q   <= eng_sim;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        rsp_sim_q   <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign eng_start     = eng_start_q;
    assign eng_vec_a     = eng_vec_a_q;
    assign eng_vec_b     = eng_vec_b_q;
    assign busy          = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sim   = rsp_sim_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_cosine_sim_sched.sv
// Self-checking bench for cosine_sim_sched: directed scenarios plus random
// traffic against a transaction-level scoreboard and a behavioural engine.
module tb_cosine_sim_sched;
    localparam int NREQ    = 4;
    localparam int W       = 5;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;
    localparam int VW      = W * DW;
    localparam int IDW     = 2;

    logic            clk;
    logic            rst_n;
    logic            eng_start;
    logic [VW-1:0]   eng_vec_a;
    logic [VW-1:0]   eng_vec_b;
    logic [DW-1:0]   eng_sim;
    logic            eng_valid;
    logic            busy;

    cosine_sim_sched_if #(.NREQ(NREQ), .W(W), .DW(DW)) bus_if ();

    cosine_sim_sched #(.NREQ(NREQ), .W(W), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if.slave),
        .eng_start (eng_start),
        .eng_vec_a (eng_vec_a),
        .eng_vec_b (eng_vec_b),
        .eng_sim   (eng_sim),
        .eng_valid (eng_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // scoreboard / model state
    int              cyc = 0;
    int              mptr = 0;
    int              gnt_cyc = 0;
    int              start_cyc = 0;
    int              n_start = 0;
    int              n_rsp = 0;
    int              exp_id = 0;
    logic [VW-1:0]   exp_a = '0;
    logic [VW-1:0]   exp_b = '0;
    logic [NREQ-1:0] last_gnt = '0;
    logic            p_valid = 1'b0;
    logic            p_ready = 1'b0;
    logic [IDW-1:0]  p_id = '0;
    logic [DW-1:0]   p_sim = '0;
    logic            p_err = 1'b0;

    // engine model / stimulus control
    int              lat_sel = 5;
    int              cur_lat = 0;
    int              cd = 0;
    logic [DW-1:0]   cur_val = '0;
    int              mode = 0;

    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_winner(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (((r >> ((p + k) % NREQ)) & NREQ'(1)) != '0) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic raise(input int r);
        for (int e = 0; e < W; e++) begin
            bus_if.req_vec_a[(r * W + e) * DW +: DW] = $urandom;
            bus_if.req_vec_b[(r * W + e) * DW +: DW] = $urandom;
        end
        bus_if.req = bus_if.req | (NREQ'(1) << r);
    endtask

    // Observes one cycle at the falling edge and checks it against the model.
    task automatic sample();
        int w;
        bit ok;
        cyc++;
        last_gnt = bus_if.gnt;
        if (bus_if.gnt != '0) begin
            w = exp_winner(bus_if.req, mptr);
            chk("gnt_rr", VW'(bus_if.gnt), VW'((w < 0) ? {NREQ{1'b0}} : (NREQ'(1) << w)));
            chk("gnt_while_busy", VW'(busy), VW'(1'b0));
            if (w >= 0) begin
                exp_id = w;
                exp_a  = bus_if.req_vec_a[w * VW +: VW];
                exp_b  = bus_if.req_vec_b[w * VW +: VW];
                mptr   = (w + 1) % NREQ;
            end
            gnt_cyc = cyc;
        end
        if (eng_start) begin
            chk("start_after_gnt", VW'(cyc - gnt_cyc), VW'(1));
            chk("eng_vec_a", eng_vec_a, exp_a);
            chk("eng_vec_b", eng_vec_b, exp_b);
            start_cyc = cyc;
            n_start++;
        end
        ok = (cur_lat >= 1 && cur_lat <= TIMEOUT);
        if (bus_if.rsp_valid && !p_valid)
            chk("rsp_latency", VW'(cyc - start_cyc), VW'(ok ? cur_lat + 1 : TIMEOUT + 1));
        if (bus_if.rsp_valid && p_valid && !p_ready) begin
            chk("hold_id", VW'(bus_if.rsp_id), VW'(p_id));
            chk("hold_sim", VW'(bus_if.rsp_sim), VW'(p_sim));
            chk("hold_err", VW'(bus_if.rsp_err), VW'(p_err));
        end
        if (bus_if.rsp_valid && bus_if.rsp_ready) begin
            n_rsp++;
            chk("rsp_id", VW'(bus_if.rsp_id), VW'(exp_id));
            chk("rsp_err", VW'(bus_if.rsp_err), VW'(!ok));
            chk("rsp_sim", VW'(bus_if.rsp_sim), ok ? VW'(cur_val) : VW'(0));
            chk("rsp_per_start", VW'(n_rsp), VW'(n_start));
        end
        p_valid = bus_if.rsp_valid;
        p_ready = bus_if.rsp_ready;
        p_id    = bus_if.rsp_id;
        p_sim   = bus_if.rsp_sim;
        p_err   = bus_if.rsp_err;
    endtask

    // Drives engine model and requesters just after the rising edge.
    task automatic drive();
        eng_valid = 1'b0;
        eng_sim   = $urandom;
        if (eng_start) begin
            cur_lat = (lat_sel < 0) ? int'($urandom_range(1, TIMEOUT + 2)) : lat_sel;
            cd      = cur_lat;
            cur_val = $urandom;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                eng_valid = 1'b1;
                eng_sim   = cur_val;
            end
        end
        if (mode != 2) bus_if.req = bus_if.req & ~last_gnt;
        if (mode == 1) begin
            for (int r = 0; r < NREQ; r++)
                if (((bus_if.req >> r) & NREQ'(1)) == '0 && $urandom_range(0, 3) == 0) raise(r);
            bus_if.rsp_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic wait_gnt(input string tag, input logic [NREQ-1:0] expg);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            if (last_gnt != '0) begin
                seen = 1'b1;
                chk(tag, VW'(last_gnt), VW'(expg));
            end
        end
        chk({tag, "_seen"}, VW'(seen), VW'(1));
    endtask

    task automatic wait_rsp(input string tag);
        int r0;
        r0 = n_rsp;
        for (int i = 0; i < 300 && n_rsp == r0; i++) step();
        chk({tag, "_rsp"}, VW'(n_rsp - r0), VW'(1));
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 3000 && (bus_if.req != '0 || busy); i++) step();
        chk(tag, VW'(bus_if.req != '0 || busy), VW'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int s0, gi;
        logic [IDW-1:0] h_id;
        logic [DW-1:0]  h_sim;

        rst_n = 1'b0;
        bus_if.req = '0;
        bus_if.req_vec_a = '0;
        bus_if.req_vec_b = '0;
        bus_if.rsp_ready = 1'b0;
        eng_valid = 1'b0;
        eng_sim = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", VW'(busy), VW'(0));
        chk("rst_start", VW'(eng_start), VW'(0));
        chk("rst_rsp_valid", VW'(bus_if.rsp_valid), VW'(0));
        chk("rst_rsp_err", VW'(bus_if.rsp_err), VW'(0));
        chk("rst_rsp_sim", VW'(bus_if.rsp_sim), VW'(0));
        chk("rst_vec_a", eng_vec_a, VW'(0));
        rst_n = 1'b1;

        // single requester 1, all-ones Q15 operands
        lat_sel = 10;
        bus_if.rsp_ready = 1'b1;
        raise(1);
        for (int e = 0; e < W; e++) begin
            bus_if.req_vec_a[(W + e) * DW +: DW] = 32'h0000_8000;
            bus_if.req_vec_b[(W + e) * DW +: DW] = 32'h0000_8000;
        end
        s0 = n_start;
        wait_gnt("t1_gnt", NREQ'(4'b0010));
        wait_rsp("t1");
        chk("t1_one_start", VW'(n_start - s0), VW'(1));
        chk("t1_id", VW'(p_id), VW'(1));
        chk("t1_err", VW'(p_err), VW'(0));

        // bring pointer to 3, then 2 and 3 together: 3 wins first
        lat_sel = 3;
        raise(2);
        wait_gnt("rr_pre", NREQ'(4'b0100));
        wait_rsp("rr_pre");
        raise(2);
        raise(3);
        wait_gnt("rr_first", NREQ'(4'b1000));
        wait_gnt("rr_second", NREQ'(4'b0100));
        wait_rsp("rr_second");

        // watchdog expiry, then a late engine pulse
        lat_sel = 0;
        raise(0);
        wait_rsp("timeout");
        chk("timeout_err", VW'(p_err), VW'(1));
        chk("timeout_sim", VW'(p_sim), VW'(0));
        eng_valid = 1'b1;
        eng_sim = 32'hDEAD_BEEF;
        s0 = n_rsp;
        repeat (5) begin
            step();
            chk("late_no_rsp", VW'(bus_if.rsp_valid), VW'(0));
        end
        chk("late_rsp_count", VW'(n_rsp - s0), VW'(0));

        // response back-pressure
        lat_sel = 4;
        bus_if.rsp_ready = 1'b0;
        raise(1);
        for (int i = 0; i < 100 && !bus_if.rsp_valid; i++) step();
        chk("stall_seen", VW'(bus_if.rsp_valid), VW'(1));
        h_id = bus_if.rsp_id;
        h_sim = bus_if.rsp_sim;
        raise(2);
        raise(3);
        repeat (10) begin
            step();
            chk("stall_valid", VW'(bus_if.rsp_valid), VW'(1));
            chk("stall_id", VW'(bus_if.rsp_id), VW'(h_id));
            chk("stall_sim", VW'(bus_if.rsp_sim), VW'(h_sim));
            chk("stall_busy", VW'(busy), VW'(1));
            chk("stall_gnt", VW'(last_gnt), VW'(0));
        end
        bus_if.rsp_ready = 1'b1;
        step();
        chk("stall_release_busy", VW'(busy), VW'(0));
        chk("stall_release_valid", VW'(bus_if.rsp_valid), VW'(0));
        drain("stall_drain");

        // reset in the middle of WAIT
        lat_sel = 0;
        raise(1);
        for (int i = 0; i < 20 && !busy; i++) step();
        repeat (4) step();
        chk("pre_rst_busy", VW'(busy), VW'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", VW'(busy), VW'(0));
        chk("mid_rst_start", VW'(eng_start), VW'(0));
        chk("mid_rst_valid", VW'(bus_if.rsp_valid), VW'(0));
        chk("mid_rst_id", VW'(bus_if.rsp_id), VW'(0));
        chk("mid_rst_vec_a", eng_vec_a, VW'(0));
        chk("mid_rst_vec_b", eng_vec_b, VW'(0));
        mptr = 0;
        cd = 0;
        n_start = n_rsp;
        p_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        lat_sel = 6;
        raise(0);
        raise(3);
        wait_gnt("post_rst_gnt", NREQ'(4'b0001));
        drain("post_rst_drain");

        // all requests held continuously: strict 0,1,2,3 rotation
        mode = 2;
        lat_sel = -1;
        for (int r = 0; r < NREQ; r++) raise(r);
        gi = 0;
        for (int i = 0; i < 3000 && gi < 12; i++) begin
            step();
            if (last_gnt != '0) begin
                chk("hold_all_order", VW'(last_gnt), VW'(NREQ'(1) << (gi % NREQ)));
                gi++;
            end
        end
        chk("hold_all_count", VW'(gi), VW'(12));
        mode = 0;
        drain("hold_all_drain");

        // random traffic
        mode = 1;
        repeat (1500) step();
        mode = 0;
        bus_if.rsp_ready = 1'b1;
        drain("random_drain");
        chk("all_served", VW'(n_rsp), VW'(n_start));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
